// File: rtl/uart_cfg_pkg.sv
// rtl/uart_cfg_pkg.sv - shared types and constants for the UART configuration sequencer
// Purpose: FSM state encoding, register map, reset defaults and small helpers
//          used by uart_cfg_ctrl and uart_cfg_timeout.
// Ports:   none (package).
package uart_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADDR = 3'd1,
        ST_DHI  = 3'd2,
        ST_DLO  = 3'd3,
        ST_CSUM = 3'd4,
        ST_EXEC = 3'd5,
        ST_RESP = 3'd6
    } state_e;

    localparam int unsigned NUM_REGS = 4;

    localparam logic [7:0] ADDR_A = 8'h00;
    localparam logic [7:0] ADDR_B = 8'h01;
    localparam logic [7:0] ADDR_C = 8'h02;
    localparam logic [7:0] ADDR_D = 8'h03;

    localparam logic [7:0]  CFG_A_RST = 8'h08;
    localparam logic [15:0] CFG_B_RST = 16'h0000;
    localparam logic [15:0] CFG_C_RST = 16'h0000;
    localparam logic [7:0]  CFG_D_RST = 8'h00;

    // Saturating 8-bit increment for the error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // One-hot register select; all-zero for an address outside the map.
    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [7:0] a);
        logic [NUM_REGS-1:0] oh;
        oh = '0;
        if (a <= ADDR_D) begin
            oh[a[1:0]] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/uart_cfg_timeout.sv
// rtl/uart_cfg_timeout.sv - loadable inter-byte timeout down-counter
// Purpose: reloads to LOAD_VAL on clear, counts down while enabled and flags
//          expiry in the cycle the count sits at zero with enable high.
// Ports:   clk_i, rst_i (sync, active-high), clr_i (reload), en_i (count),
//          expire_o (timeout reached).
module uart_cfg_timeout #(
    parameter int unsigned CW       = 16,
    parameter int unsigned LOAD_VAL = 49999
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= CW'(LOAD_VAL);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign expire_o = en_i && (cnt_q == '0);

endmodule

// File: rtl/uart_cfg_ctrl.sv
// rtl/uart_cfg_ctrl.sv - UART command sequencer writing DDS configuration registers
// Purpose: frames HDR/ADDR/D_HI/D_LO[/CSUM] write packets from the UART byte
//          stream, updates one of four config registers, answers ACK/NAK.
// Build option: UART_CFG_CSUM_EN defined -> 5-byte packet with XOR checksum;
//               undefined -> 4-byte packet, only the address range is checked.
// Ports:   sys_clk, sys_rst (sync, active-high); rx_data/rx_done byte input;
//          tx_data/tx_valid/tx_ready response handshake; cfg_a..cfg_d register
//          outputs; cfg_upd one-hot write pulse; busy; err_cnt (saturating).
module uart_cfg_ctrl
    import uart_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 50000,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5,
    parameter logic [7:0]  ACK_BYTE    = 8'h06,
    parameter logic [7:0]  NAK_BYTE    = 8'h15
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_done,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  cfg_a,
    output logic [15:0] cfg_b,
    output logic [15:0] cfg_c,
    output logic [7:0]  cfg_d,
    output logic [3:0]  cfg_upd,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int unsigned TO_CW = $clog2(TIMEOUT_CYC);

    state_e              state_q;
    logic [7:0]          addr_q;
    logic [7:0]          dhi_q;
    logic [7:0]          dlo_q;
    logic [NUM_REGS-1:0] upd_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic [7:0]          err_q;
    logic [7:0]          cfg_a_q;
    logic [15:0]         cfg_b_q;
    logic [15:0]         cfg_c_q;
    logic [7:0]          cfg_d_q;
`ifdef UART_CFG_CSUM_EN
    logic [7:0]          csum_q;
`endif

    logic                counting;
    logic                expire;
    logic [NUM_REGS-1:0] upd_d;

    // upd_d is evaluated on the last byte of the packet; a non-zero value
    // means the packet is accepted, so EXEC only has to look at upd_q.
    always_comb begin
        counting = 1'b0;
        upd_d    = addr_onehot(addr_q);
`ifdef UART_CFG_CSUM_EN
        counting = (state_q == ST_ADDR) || (state_q == ST_DHI) ||
                   (state_q == ST_DLO)  || (state_q == ST_CSUM);
        if (csum_q != rx_data) begin
            upd_d = '0;
        end
`else
        counting = (state_q == ST_ADDR) || (state_q == ST_DHI) ||
                   (state_q == ST_DLO);
`endif
    end

    uart_cfg_timeout #(
        .CW       (TO_CW),
        .LOAD_VAL (TIMEOUT_CYC - 1)
    ) u_timeout (
        .clk_i    (sys_clk),
        .rst_i    (sys_rst),
        .clr_i    (rx_done || !counting),
        .en_i     (counting && !rx_done),
        .expire_o (expire)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            upd_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            err_q      <= '0;
            cfg_a_q    <= CFG_A_RST;
            cfg_b_q    <= CFG_B_RST;
            cfg_c_q    <= CFG_C_RST;
            cfg_d_q    <= CFG_D_RST;
`ifdef UART_CFG_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_done && (rx_data == HDR_BYTE)) begin
                        state_q <= ST_ADDR;
`ifdef UART_CFG_CSUM_EN
                        csum_q  <= rx_data;
`endif
                    end
                end
                ST_ADDR: begin
                    if (rx_done) begin
                        addr_q  <= rx_data;
                        state_q <= ST_DHI;
`ifdef UART_CFG_CSUM_EN
                        csum_q  <= csum_q ^ rx_data;
`endif
                    end else if (expire) begin
                        err_q   <= sat_inc8(err_q);
                        state_q <= ST_IDLE;
                    end
                end
                ST_DHI: begin
                    if (rx_done) begin
                        dhi_q   <= rx_data;
                        state_q <= ST_DLO;
`ifdef UART_CFG_CSUM_EN
                        csum_q  <= csum_q ^ rx_data;
`endif
                    end else if (expire) begin
                        err_q   <= sat_inc8(err_q);
                        state_q <= ST_IDLE;
                    end
                end
                ST_DLO: begin
                    if (rx_done) begin
                        dlo_q   <= rx_data;
`ifdef UART_CFG_CSUM_EN
                        csum_q  <= csum_q ^ rx_data;
                        state_q <= ST_CSUM;
`else
                        upd_q   <= upd_d;
                        state_q <= ST_EXEC;
`endif
                    end else if (expire) begin
                        err_q   <= sat_inc8(err_q);
                        state_q <= ST_IDLE;
                    end
                end
`ifdef UART_CFG_CSUM_EN
                ST_CSUM: begin
                    if (rx_done) begin
                        upd_q   <= upd_d;
                        state_q <= ST_EXEC;
                    end else if (expire) begin
                        err_q   <= sat_inc8(err_q);
                        state_q <= ST_IDLE;
                    end
                end
`endif
                ST_EXEC: begin
                    // Register write lands on the edge that ends the upd pulse.
                    upd_q      <= '0;
                    tx_valid_q <= 1'b1;
                    state_q    <= ST_RESP;
                    if (upd_q != '0) begin
                        tx_data_q <= ACK_BYTE;
                        if (upd_q[0]) cfg_a_q <= dlo_q;
                        if (upd_q[1]) cfg_b_q <= {dhi_q, dlo_q};
                        if (upd_q[2]) cfg_c_q <= {dhi_q, dlo_q};
                        if (upd_q[3]) cfg_d_q <= dlo_q;
                    end else begin
                        tx_data_q <= NAK_BYTE;
                        err_q     <= sat_inc8(err_q);
                    end
                end
                ST_RESP: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign cfg_a    = cfg_a_q;
    assign cfg_b    = cfg_b_q;
    assign cfg_c    = cfg_c_q;
    assign cfg_d    = cfg_d_q;
    assign cfg_upd  = upd_q;
    assign busy     = (state_q != ST_IDLE);
    assign err_cnt  = err_q;

endmodule

// File: tb/tb_uart_cfg_ctrl.sv
// tb/tb_uart_cfg_ctrl.sv - directed self-checking bench for uart_cfg_ctrl
module tb_uart_cfg_ctrl;

    localparam int unsigned TO = 16;
`ifdef UART_CFG_CSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_done = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  cfg_a;
    logic [15:0] cfg_b;
    logic [15:0] cfg_c;
    logic [7:0]  cfg_d;
    logic [3:0]  cfg_upd;
    logic        busy;
    logic [7:0]  err_cnt;

    int n_vec = 0;
    int n_err = 0;

    uart_cfg_ctrl #(
        .TIMEOUT_CYC (TO),
        .HDR_BYTE    (8'hA5),
        .ACK_BYTE    (8'h06),
        .NAK_BYTE    (8'h15)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .rx_data  (rx_data),
        .rx_done  (rx_done),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .cfg_a    (cfg_a),
        .cfg_b    (cfg_b),
        .cfg_c    (cfg_c),
        .cfg_d    (cfg_d),
        .cfg_upd  (cfg_upd),
        .busy     (busy),
        .err_cnt  (err_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Single-cycle rx_done strobe, one idle cycle before it.
    task automatic send_byte(input logic [7:0] b);
        @(posedge sys_clk); #1;
        rx_data = b;
        rx_done = 1'b1;
        @(posedge sys_clk); #1;
        rx_done = 1'b0;
    endtask

    // Returns one cycle after the final byte was sampled (FSM in EXEC).
    task automatic send_pkt(input logic [7:0] a, input logic [7:0] hi,
                            input logic [7:0] lo, input bit bad_csum);
        logic [7:0] cs;
        cs = 8'hA5 ^ a ^ hi ^ lo;
        if (bad_csum) cs = 8'h00;
        send_byte(8'hA5);
        send_byte(a);
        send_byte(hi);
        send_byte(lo);
        if (CS) send_byte(cs);
    endtask

    task automatic wait_resp(input string tag, input logic [7:0] exp);
        int k;
        k = 0;
        while (!tx_valid && k < 10) begin
            @(posedge sys_clk); #1;
            k++;
        end
        check_eq({tag, "_valid"}, {31'd0, tx_valid}, 32'd1);
        check_eq({tag, "_data"}, {24'd0, tx_data}, {24'd0, exp});
        tx_ready = 1'b1;
        @(posedge sys_clk); #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit stable;

        // Reset state
        repeat (2) @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        check_eq("rst_cfg_a", {24'd0, cfg_a}, 32'h08);
        check_eq("rst_cfg_b", {16'd0, cfg_b}, 32'h0);
        check_eq("rst_cfg_c", {16'd0, cfg_c}, 32'h0);
        check_eq("rst_cfg_d", {24'd0, cfg_d}, 32'h0);
        check_eq("rst_misc", {tx_data, 3'd0, tx_valid, cfg_upd, 3'd0, busy, err_cnt},
                 32'h0);

        // Non-header byte in IDLE is discarded
        send_byte(8'h3C);
        check_eq("idle_discard", {31'd0, busy}, 32'd0);

        // Valid write to B with timing of upd pulse and register update
        send_pkt(8'h01, 8'h12, 8'h34, 1'b0);
        check_eq("b_upd_pulse", {28'd0, cfg_upd}, 32'b0010);
        check_eq("b_not_yet", {16'd0, cfg_b}, 32'h0);
        @(posedge sys_clk); #1;
        check_eq("b_upd_fall", {28'd0, cfg_upd}, 32'd0);
        check_eq("b_value", {16'd0, cfg_b}, 32'h1234);
        check_eq("b_ack_valid", {31'd0, tx_valid}, 32'd1);
        check_eq("b_ack_data", {24'd0, tx_data}, 32'h06);

        // Backpressure with header bytes arriving during RESP
        stable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rx_done = (i % 10 == 3);
            rx_data = 8'hA5;
            @(posedge sys_clk); #1;
            if (!tx_valid || tx_data !== 8'h06 || !busy) stable = 1'b0;
        end
        rx_done = 1'b0;
        check_eq("bp_stable", {31'd0, stable}, 32'd1);
        tx_ready = 1'b1;
        @(posedge sys_clk); #1;
        tx_ready = 1'b0;
        check_eq("bp_released", {30'd0, tx_valid, busy}, 32'd0);
        @(posedge sys_clk); #1;
        check_eq("bp_no_reframe", {31'd0, busy}, 32'd0);

        // Bad checksum to C (only rejected in the checksum build)
        send_pkt(8'h02, 8'h00, 8'h10, 1'b1);
        wait_resp("csum", CS ? 8'h15 : 8'h06);
        check_eq("csum_cfg_c", {16'd0, cfg_c}, CS ? 32'h0 : 32'h0010);
        check_eq("csum_err", {24'd0, err_cnt}, CS ? 32'd1 : 32'd0);

        // Address out of range
        send_pkt(8'h07, 8'h00, 8'h01, 1'b0);
        check_eq("addr_no_upd", {28'd0, cfg_upd}, 32'd0);
        wait_resp("addr", 8'h15);
        check_eq("addr_err", {24'd0, err_cnt}, CS ? 32'd2 : 32'd1);

        // Timeout after HDR ADDR: still busy one cycle before expiry
        send_byte(8'hA5);
        send_byte(8'h00);
        repeat (TO - 1) @(posedge sys_clk);
        #1;
        check_eq("to_before", {31'd0, busy}, 32'd1);
        @(posedge sys_clk); #1;
        check_eq("to_idle", {30'd0, busy, tx_valid}, 32'd0);
        check_eq("to_err", {24'd0, err_cnt}, CS ? 32'd3 : 32'd2);
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("to_no_resp", {31'd0, tx_valid}, 32'd0);

        // 8-bit registers take D_LO only
        send_pkt(8'h00, 8'hFF, 8'h3C, 1'b0);
        check_eq("a_upd_pulse", {28'd0, cfg_upd}, 32'b0001);
        wait_resp("a", 8'h06);
        check_eq("a_value", {24'd0, cfg_a}, 32'h3C);
        send_pkt(8'h03, 8'h5A, 8'hC3, 1'b0);
        check_eq("d_upd_pulse", {28'd0, cfg_upd}, 32'b1000);
        wait_resp("d", 8'h06);
        check_eq("d_value", {24'd0, cfg_d}, 32'hC3);
        check_eq("abd_others", {cfg_b, cfg_c}, CS ? 32'h1234_0000 : 32'h1234_0010);

        // Error counter saturation
        for (int i = 0; i < 260; i++) begin
            send_pkt(8'h80, 8'h00, 8'h00, 1'b0);
            wait_resp("sat", 8'h15);
        end
        check_eq("err_sat", {24'd0, err_cnt}, 32'hFF);

        // Reset after the D_HI byte
        send_byte(8'hA5);
        send_byte(8'h03);
        send_byte(8'h77);
        sys_rst = 1'b1;
        @(posedge sys_clk); #1;
        sys_rst = 1'b0;
        check_eq("mid_rst_a", {24'd0, cfg_a}, 32'h08);
        check_eq("mid_rst_bc", {cfg_b, cfg_c}, 32'h0);
        check_eq("mid_rst_misc", {tx_data, 3'd0, tx_valid, cfg_upd, 3'd0, busy, err_cnt},
                 32'h0);
        send_byte(8'h88);
        if (CS) send_byte(8'h00);
        repeat (3) @(posedge sys_clk);
        #1;
        check_eq("mid_rst_no_resp", {30'd0, tx_valid, busy}, 32'd0);
        check_eq("mid_rst_d", {24'd0, cfg_d}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
